// File: rtl/noc_pe_injector.sv
// PE transmit interface: builds mesh headers, buffers requests, injects on pesi/pedi/peri; accept->pesi is 2 edges.
// Backpressure: req_ready drops when the FIFO is full; pedi holds while pesi && !peri.
module noc_pe_injector #(
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_des,
    input  logic [31:0] req_payload,
    output logic        pesi,
    output logic [63:0] pedi,
    input  logic        peri,
    output logic [15:0] tx_count,
    output logic        err_self
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [1:0] MX      = 2'(MY_X);
    localparam logic [1:0] MYY     = 2'(MY_Y);
    localparam logic [3:0] MY_ID   = 4'(MY_Y * 4 + MY_X);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t      r_state;
    logic [63:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;

    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_self;
    logic        w_push;
    logic        w_pop;
    logic        w_xfer;
    logic [1:0]  w_des_x;
    logic [1:0]  w_des_y;
    logic        w_dir_x;
    logic        w_dir_y;
    logic [1:0]  w_hop_x;
    logic [1:0]  w_hop_y;
    logic [63:0] w_pkt;
    logic [63:0] w_head;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head   = r_mem[r_rptr[AW-1:0]];

    assign req_ready = reset && !w_full;
    assign w_accept  = req_valid && req_ready;
    assign w_self    = (req_des == MY_ID);
    assign w_push    = w_accept && !w_self;
    assign w_xfer    = pesi && peri;
    assign w_pop     = !w_empty && ((r_state == IDLE) || w_xfer);

    assign w_des_x = req_des[1:0];
    assign w_des_y = req_des[3:2];
    assign w_dir_x = (w_des_x > MX);
    assign w_dir_y = (w_des_y > MYY);
    assign w_hop_x = w_dir_x ? (w_des_x - MX)  : (MX - w_des_x);
    assign w_hop_y = w_dir_y ? (w_des_y - MYY) : (MYY - w_des_y);
    assign w_pkt   = {1'b0, w_dir_x, w_dir_y, 5'b0, 2'b0, w_hop_x, 2'b0, w_hop_y,
                      8'(MY_X), 8'(MY_Y), req_payload};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_pkt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Output register doubles as the one-deep skid stage in front of the router.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            pesi     <= 1'b0;
            pedi     <= '0;
            tx_count <= '0;
            err_self <= 1'b0;
        end else begin
            err_self <= w_accept && w_self;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        pedi    <= w_head;
                        pesi    <= 1'b1;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        tx_count <= tx_count + 16'd1;
                        if (!w_empty) begin
                            pedi <= w_head;
                        end else begin
                            pesi    <= 1'b0;
                            pedi    <= '0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    pesi    <= 1'b0;
                    pedi    <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_noc_pe_injector.sv
// Two injectors (nodes (0,2) and (2,2)) share stimulus; a queue-based model predicts every output each cycle.
module tb_noc_pe_injector;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_des;
    logic [31:0] req_payload;
    logic        peri;

    logic        rdy_a, pesi_a, err_a;
    logic [63:0] pedi_a;
    logic [15:0] tx_a;
    logic        rdy_b, pesi_b, err_b;
    logic [63:0] pedi_b;
    logic [15:0] tx_b;

    always #5 clk = ~clk;

    noc_pe_injector #(.MY_X(0), .MY_Y(2), .FIFO_DEPTH(DEPTH)) u_dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_a),
        .req_des(req_des), .req_payload(req_payload), .pesi(pesi_a), .pedi(pedi_a),
        .peri(peri), .tx_count(tx_a), .err_self(err_a)
    );

    noc_pe_injector #(.MY_X(2), .MY_Y(2), .FIFO_DEPTH(DEPTH)) u_dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_b),
        .req_des(req_des), .req_payload(req_payload), .pesi(pesi_b), .pedi(pedi_b),
        .peri(peri), .tx_count(tx_b), .err_self(err_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk_pkt(input int mx, input int my, input int des,
                                          input logic [31:0] pl);
        int dx, dy, hx, hy;
        logic d1, d0;
        dx = des % 4;
        dy = des / 4;
        d1 = (dx > mx);
        d0 = (dy > my);
        hx = (dx > mx) ? dx - mx : mx - dx;
        hy = (dy > my) ? dy - my : my - dy;
        return {1'b0, d1, d0, 5'b0, 4'(hx), 4'(hy), 8'(mx), 8'(my), pl};
    endfunction

    // Reference model: per node a packet queue plus the outstanding output word.
    int          mx [2] = '{0, 2};
    int          my [2] = '{2, 2};
    bit          m_pesi [2];
    logic [63:0] m_pedi [2];
    logic [15:0] m_tx   [2];
    bit          m_err  [2];
    logic [63:0] mq [2][$];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_pesi[i] = 1'b0;
                m_pedi[i] = '0;
                m_tx[i]   = '0;
                m_err[i]  = 1'b0;
                mq[i].delete();
            end else begin
                bit acc, xfer, self_hit, can_pop;
                acc      = req_valid && (mq[i].size() < DEPTH);
                xfer     = m_pesi[i] && peri;
                self_hit = (int'(req_des) == my[i] * 4 + mx[i]);
                can_pop  = (!m_pesi[i] || xfer) && (mq[i].size() > 0);
                if (xfer) m_tx[i] = m_tx[i] + 16'd1;
                if (can_pop) begin
                    m_pedi[i] = mq[i].pop_front();
                    m_pesi[i] = 1'b1;
                end else if (xfer) begin
                    m_pesi[i] = 1'b0;
                    m_pedi[i] = '0;
                end
                m_err[i] = acc && self_hit;
                if (acc && !self_hit)
                    mq[i].push_back(mk_pkt(mx[i], my[i], int'(req_des), req_payload));
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a.pesi",  64'(pesi_a), 64'(m_pesi[0]));
            chk("a.pedi",  pedi_a,      m_pedi[0]);
            chk("a.tx",    64'(tx_a),   64'(m_tx[0]));
            chk("a.err",   64'(err_a),  64'(m_err[0]));
            chk("a.ready", 64'(rdy_a),  64'(reset && (mq[0].size() < DEPTH)));
            chk("b.pesi",  64'(pesi_b), 64'(m_pesi[1]));
            chk("b.pedi",  pedi_b,      m_pedi[1]);
            chk("b.tx",    64'(tx_b),   64'(m_tx[1]));
            chk("b.err",   64'(err_b),  64'(m_err[1]));
            chk("b.ready", 64'(rdy_b),  64'(reset && (mq[1].size() < DEPTH)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;
        reset = 1'b0; req_valid = 1'b0; peri = 1'b0; req_des = '0; req_payload = '0;

        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst.pesi",  64'(pesi_a), 64'd0);
        chk("rst.pedi",  pedi_a,      64'd0);
        chk("rst.ready", 64'(rdy_a),  64'd0);
        chk("rst.tx",    64'(tx_a),   64'd0);
        reset = 1'b1;
        #1;
        chk("rel.ready", 64'(rdy_a), 64'd1);

        // Eastbound single packet from node (0,2) to node 9.
        peri = 1'b1; req_valid = 1'b1; req_des = 4'd9; req_payload = 32'h8888_0000;
        tick();
        req_valid = 1'b0;
        tick();
        chk("east.pedi", pedi_a,      64'h4010_0002_8888_0000);
        chk("east.pesi", 64'(pesi_a), 64'd1);
        tick();
        chk("east.tx",   64'(tx_a),   64'd1);

        // Node (2,2) sending to node 5: both directions negative.
        req_valid = 1'b1; req_des = 4'd5; req_payload = 32'hAAAA_0005;
        tick();
        req_valid = 1'b0;
        tick();
        chk("west.pedi", pedi_b,    64'h0011_0202_AAAA_0005);
        tick();
        chk("west.tx",   64'(tx_b), 64'd2);

        // Stall with three queued, then drain back-to-back.
        peri = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1; req_des = 4'(k + 1); req_payload = 32'h4000_0000 + 32'(k);
            tick();
        end
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall.pedi", pedi_a, 64'h4012_0002_4000_0000);
        end
        peri = 1'b1;
        tick();
        chk("b2b.tx1",   64'(tx_a),   64'd3);
        chk("b2b.pedi1", pedi_a,      64'h4022_0002_4000_0001);
        tick();
        chk("b2b.tx2",   64'(tx_a),   64'd4);
        chk("b2b.pedi2", pedi_a,      64'h4032_0002_4000_0002);
        tick();
        chk("b2b.tx3",   64'(tx_a),   64'd5);
        chk("b2b.idle",  64'(pesi_a), 64'd0);

        // Fill to capacity: four in FIFO plus one in the output register.
        peri = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_des = 4'd1; req_payload = 32'h5000_0000 + 32'(k);
            #1;
            chk("fill.ready", 64'(rdy_a), (k < 5) ? 64'd1 : 64'd0);
            tick();
        end
        chk("full.ready", 64'(rdy_a), 64'd0);
        peri = 1'b1;
        tick();
        peri = 1'b0;
        chk("pulse.ready", 64'(rdy_a), 64'd1);
        tick();
        req_valid = 1'b0;
        chk("refill.ready", 64'(rdy_a), 64'd0);
        peri = 1'b1;
        budget = 0;
        while (pesi_a && budget < 40) begin
            tick();
            budget++;
        end
        chk("drain.timeout", 64'(pesi_a), 64'd0);
        chk("drain.tx",      64'(tx_a),   64'd11);

        // Self-addressed request on node (0,2).
        req_valid = 1'b1; req_des = 4'd8; req_payload = 32'h0000_0066;
        tick();
        req_valid = 1'b0;
        chk("self.err",  64'(err_a),  64'd1);
        chk("self.pesi", 64'(pesi_a), 64'd0);
        tick();
        chk("self.err0", 64'(err_a),  64'd0);
        chk("self.pesi2",64'(pesi_a), 64'd0);
        chk("self.tx",   64'(tx_a),   64'd11);
        tick();

        // Reset while a packet is in flight and another is queued.
        peri = 1'b0; req_valid = 1'b1; req_des = 4'd1; req_payload = 32'h7777_0000;
        tick();
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid.pesi", 64'(pesi_a), 64'd1);
        reset = 1'b0;
        tick();
        chk("mid.rst.pesi",  64'(pesi_a), 64'd0);
        chk("mid.rst.ready", 64'(rdy_a),  64'd0);
        reset = 1'b1;
        #1;
        chk("mid.rel.ready", 64'(rdy_a), 64'd1);
        tick();
        chk("mid.empty.pesi", 64'(pesi_a), 64'd0);
        tick();
        chk("mid.empty.pedi", pedi_a,    64'd0);
        chk("mid.tx",         64'(tx_a), 64'd0);

        // Randomized traffic with varying peri density and rare resets.
        for (int blk = 0; blk < 6; blk++) begin
            int dens;
            dens = $urandom_range(1, 9);
            for (int c = 0; c < 500; c++) begin
                reset       = ($urandom_range(0, 299) != 0);
                req_valid   = ($urandom_range(0, 9) < 6);
                req_des     = 4'($urandom_range(0, 15));
                req_payload = $urandom;
                peri        = ($urandom_range(0, 9) < dens);
                tick();
            end
        end

        reset = 1'b1; req_valid = 1'b0; peri = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
